// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the MIPS pipeline-control sequencer: FSM states,
// opcode/funct constants and small instruction-decode helpers.
package pipe_ctrl_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } ctrl_state_t;

  localparam logic [5:0] RTYPE    = 6'b000000;
  localparam logic [5:0] J        = 6'b000010;
  localparam logic [5:0] JAL      = 6'b000011;
  localparam logic [5:0] BEQ      = 6'b000100;
  localparam logic [5:0] BNE      = 6'b000101;
  localparam logic [5:0] SW       = 6'b101011;
  localparam logic [5:0] SH       = 6'b101001;
  localparam logic [5:0] SB       = 6'b101000;
  localparam logic [5:0] JR_FUNCT = 6'b001000;

  // Instructions that read rt as a source operand (R-type, branches, stores).
  function automatic logic op_uses_rt(input logic [5:0] opcode);
    return (opcode == RTYPE) || (opcode == BEQ) || (opcode == BNE) ||
           (opcode == SW) || (opcode == SH) || (opcode == SB);
  endfunction

  function automatic logic is_jump(input logic [5:0] opcode, input logic [5:0] funct);
    return (opcode == J) || (opcode == JAL) ||
           ((opcode == RTYPE) && (funct == JR_FUNCT));
  endfunction

endpackage

// File: rtl/hazard_flush_ctrl_if.sv
// Bundle between the pipeline datapath (master) and the hazard/flush
// sequencer (slave): hazard inputs, pipeline-register controls, perf counters.
interface hazard_flush_ctrl_if;

  logic [31:0] id_instr;
  logic        ex_mem_read;
  logic [4:0]  ex_rt;
  logic        branch_taken;
  logic        perf_clear;

  logic        pc_write;
  logic        if_id_write;
  logic        if_id_flush;
  logic        id_ex_flush;
  logic [1:0]  ctrl_state;
  logic [31:0] stall_cycles;
  logic [31:0] flush_cycles;

  modport master (
    output id_instr, ex_mem_read, ex_rt, branch_taken, perf_clear,
    input  pc_write, if_id_write, if_id_flush, id_ex_flush,
           ctrl_state, stall_cycles, flush_cycles
  );

  modport slave (
    input  id_instr, ex_mem_read, ex_rt, branch_taken, perf_clear,
    output pc_write, if_id_write, if_id_flush, id_ex_flush,
           ctrl_state, stall_cycles, flush_cycles
  );

endinterface

// File: rtl/sat_counter32.sv
// 32-bit event counter that sticks at all-ones; clear wins over increment.
module sat_counter32 (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        clear,
  input  logic        inc,
  output logic [31:0] count
);

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc) begin
      count <= sat_inc(count);
    end
  end

endmodule

// File: rtl/hazard_flush_ctrl.sv
// Pipeline-control sequencer: load-use stalls, jump flushes and taken-branch
// flushes with zero-latency combinational controls and saturating perf counters.
module hazard_flush_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int LOAD_STALL   = 1,
  parameter int JUMP_FLUSH   = 1,
  parameter int BRANCH_FLUSH = 1
) (
  input logic              Clk,
  input logic              Reset,
  hazard_flush_ctrl_if.slave bus
);

  localparam logic [CNT_W-1:0] LOAD_RELOAD   = CNT_W'(LOAD_STALL - 1);
  localparam logic [CNT_W-1:0] JUMP_RELOAD   = CNT_W'(JUMP_FLUSH - 1);
  localparam logic [CNT_W-1:0] BRANCH_RELOAD = CNT_W'(BRANCH_FLUSH - 1);

  logic [5:0] opcode;
  logic [5:0] funct;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       uses_rt;
  logic       jump;
  logic       load_use;
  logic       unused_imm;

  ctrl_state_t      state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  logic pc_write;
  logic if_id_write;
  logic if_id_flush;
  logic id_ex_flush;
  logic stall_inc;
  logic [31:0] stall_cycles;
  logic [31:0] flush_cycles;

  assign opcode     = bus.id_instr[31:26];
  assign funct      = bus.id_instr[5:0];
  assign id_rs      = bus.id_instr[25:21];
  assign id_rt      = bus.id_instr[20:16];
  assign unused_imm = ^bus.id_instr[15:6];

  assign uses_rt  = op_uses_rt(opcode);
  assign jump     = is_jump(opcode, funct);
  // $zero is never a real dependency, so a load targeting it cannot hazard.
  assign load_use = bus.ex_mem_read && (bus.ex_rt != 5'd0) &&
                    ((bus.ex_rt == id_rs) || (uses_rt && (bus.ex_rt == id_rt)));

  always_comb begin
    pc_write    = 1'b1;
    if_id_write = 1'b1;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    state_nxt   = state;
    cnt_nxt     = cnt;

    case (state)
      RUN, STALL, FLUSH: begin
        if (bus.branch_taken) begin
          // A taken branch kills both younger stages no matter what else is pending.
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
          if (BRANCH_FLUSH > 1) begin
            state_nxt = FLUSH;
            cnt_nxt   = BRANCH_RELOAD;
          end else begin
            state_nxt = RUN;
            cnt_nxt   = '0;
          end
        end else if (state == FLUSH) begin
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
          if (cnt <= CNT_W'(1)) begin
            state_nxt = RUN;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt - CNT_W'(1);
          end
        end else if (state == STALL) begin
          pc_write    = 1'b0;
          if_id_write = 1'b0;
          id_ex_flush = 1'b1;
          if (cnt <= CNT_W'(1)) begin
            state_nxt = RUN;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt - CNT_W'(1);
          end
        end else if (jump) begin
          // The jump itself proceeds into ID_EX; only the fetched successor dies.
          if_id_flush = 1'b1;
          if (JUMP_FLUSH > 1) begin
            state_nxt = FLUSH;
            cnt_nxt   = JUMP_RELOAD;
          end
        end else if (load_use) begin
          pc_write    = 1'b0;
          if_id_write = 1'b0;
          id_ex_flush = 1'b1;
          if (LOAD_STALL > 1) begin
            state_nxt = STALL;
            cnt_nxt   = LOAD_RELOAD;
          end
        end
      end
      default: begin
        state_nxt = RUN;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  assign stall_inc = ~pc_write;

  sat_counter32 u_stall_cnt (
    .Clk   (Clk),
    .Reset (Reset),
    .clear (bus.perf_clear),
    .inc   (stall_inc),
    .count (stall_cycles)
  );

  sat_counter32 u_flush_cnt (
    .Clk   (Clk),
    .Reset (Reset),
    .clear (bus.perf_clear),
    .inc   (if_id_flush),
    .count (flush_cycles)
  );

  assign bus.pc_write     = pc_write;
  assign bus.if_id_write  = if_id_write;
  assign bus.if_id_flush  = if_id_flush;
  assign bus.id_ex_flush  = id_ex_flush;
  assign bus.ctrl_state   = state;
  assign bus.stall_cycles = stall_cycles;
  assign bus.flush_cycles = flush_cycles;

endmodule

// File: tb/tb_hazard_flush_ctrl.sv
// Bench for hazard_flush_ctrl: three parameterisations driven by shared
// stimulus, each compared every cycle against a cycle-count reference model.
module tb_hazard_flush_ctrl;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [31:0] id_instr;
  logic        ex_mem_read;
  logic [4:0]  ex_rt;
  logic        branch_taken;
  logic        perf_clear;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] ADD_T1_T0_T2 = 32'h010A_4820;
  localparam logic [31:0] ADD_T1_Z_Z   = 32'h0000_4820;
  localparam logic [31:0] ADDI_T1_T3_4 = 32'h2169_0004;
  localparam logic [31:0] JAL_INSTR    = 32'h0C00_0010;
  localparam logic [31:0] NOP          = 32'h0000_0000;

  // Per-instance parameters: a=(1,1,1) b=(3,3,1) c=(2,2,4)
  int    P_LS[3] = '{1, 3, 2};
  int    P_JF[3] = '{1, 3, 2};
  int    P_BF[3] = '{1, 1, 4};
  string nm[3]   = '{"a", "b", "c"};

  hazard_flush_ctrl_if bus[3] ();

  logic        o_pw[3];
  logic        o_ifw[3];
  logic        o_iff[3];
  logic        o_idf[3];
  logic [1:0]  o_st[3];
  logic [31:0] o_sc[3];
  logic [31:0] o_fc[3];

  for (genvar g = 0; g < 3; g++) begin : g_conn
    assign bus[g].id_instr     = id_instr;
    assign bus[g].ex_mem_read  = ex_mem_read;
    assign bus[g].ex_rt        = ex_rt;
    assign bus[g].branch_taken = branch_taken;
    assign bus[g].perf_clear   = perf_clear;
    assign o_pw[g]  = bus[g].pc_write;
    assign o_ifw[g] = bus[g].if_id_write;
    assign o_iff[g] = bus[g].if_id_flush;
    assign o_idf[g] = bus[g].id_ex_flush;
    assign o_st[g]  = bus[g].ctrl_state;
    assign o_sc[g]  = bus[g].stall_cycles;
    assign o_fc[g]  = bus[g].flush_cycles;
  end

  hazard_flush_ctrl #(.LOAD_STALL(1), .JUMP_FLUSH(1), .BRANCH_FLUSH(1)) dut_a (
    .Clk(Clk), .Reset(Reset), .bus(bus[0]));
  hazard_flush_ctrl #(.LOAD_STALL(3), .JUMP_FLUSH(3), .BRANCH_FLUSH(1)) dut_b (
    .Clk(Clk), .Reset(Reset), .bus(bus[1]));
  hazard_flush_ctrl #(.LOAD_STALL(2), .JUMP_FLUSH(2), .BRANCH_FLUSH(4)) dut_c (
    .Clk(Clk), .Reset(Reset), .bus(bus[2]));

  always #5 Clk = ~Clk;

  // Reference model: mode 0 running, 1 stalling, 2 flushing; left = extra cycles remaining
  int          mode[3];
  int          left[3];
  logic [31:0] m_sc[3];
  logic [31:0] m_fc[3];
  logic        e_pw[3], e_ifw[3], e_iff[3], e_idf[3];

  function automatic void decode(output bit jmp, output bit lu);
    int op, fn, rs, rt;
    bit rt_src;
    op = int'(id_instr >> 26);
    fn = int'(id_instr & 32'h3F);
    rs = int'((id_instr >> 21) & 32'h1F);
    rt = int'((id_instr >> 16) & 32'h1F);
    jmp = (op == 2) || (op == 3) || (op == 0 && fn == 8);
    rt_src = (op == 0) || (op == 4) || (op == 5) || (op == 43) || (op == 41) || (op == 40);
    lu = ex_mem_read && (int'(ex_rt) != 0) &&
         (int'(ex_rt) == rs || (rt_src && int'(ex_rt) == rt));
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 3; i++) begin
      mode[i] = 0; left[i] = 0; m_sc[i] = 0; m_fc[i] = 0;
    end
  endfunction

  function automatic void model_comb();
    bit jmp, lu;
    decode(jmp, lu);
    for (int i = 0; i < 3; i++) begin
      e_pw[i] = 1; e_ifw[i] = 1; e_iff[i] = 0; e_idf[i] = 0;
      if (branch_taken || mode[i] == 2) begin
        e_iff[i] = 1; e_idf[i] = 1;
      end else if (mode[i] == 1) begin
        e_pw[i] = 0; e_ifw[i] = 0; e_idf[i] = 1;
      end else if (jmp) begin
        e_iff[i] = 1;
      end else if (lu) begin
        e_pw[i] = 0; e_ifw[i] = 0; e_idf[i] = 1;
      end
    end
  endfunction

  function automatic void model_seq();
    bit jmp, lu;
    decode(jmp, lu);
    for (int i = 0; i < 3; i++) begin
      if (perf_clear) begin
        m_sc[i] = 0; m_fc[i] = 0;
      end else begin
        if (!e_pw[i] && m_sc[i] != 32'hFFFF_FFFF) m_sc[i] = m_sc[i] + 1;
        if (e_iff[i] && m_fc[i] != 32'hFFFF_FFFF) m_fc[i] = m_fc[i] + 1;
      end
      if (branch_taken) begin
        left[i] = P_BF[i] - 1; mode[i] = (left[i] > 0) ? 2 : 0;
      end else if (mode[i] != 0) begin
        left[i]--; if (left[i] == 0) mode[i] = 0;
      end else if (jmp) begin
        left[i] = P_JF[i] - 1; mode[i] = (left[i] > 0) ? 2 : 0;
      end else if (lu) begin
        left[i] = P_LS[i] - 1; mode[i] = (left[i] > 0) ? 1 : 0;
      end
    end
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic [31:0] ins, input logic mr, input logic [4:0] rt,
                        input logic bt, input logic clr);
    id_instr = ins; ex_mem_read = mr; ex_rt = rt; branch_taken = bt; perf_clear = clr;
  endtask

  task automatic settle();
    #1;
    model_comb();
    for (int i = 0; i < 3; i++) begin
      check({nm[i], ".pc_write"},     32'(o_pw[i]),  32'(e_pw[i]));
      check({nm[i], ".if_id_write"},  32'(o_ifw[i]), 32'(e_ifw[i]));
      check({nm[i], ".if_id_flush"},  32'(o_iff[i]), 32'(e_iff[i]));
      check({nm[i], ".id_ex_flush"},  32'(o_idf[i]), 32'(e_idf[i]));
      check({nm[i], ".ctrl_state"},   32'(o_st[i]),  32'(mode[i]));
      check({nm[i], ".stall_cycles"}, o_sc[i],       m_sc[i]);
      check({nm[i], ".flush_cycles"}, o_fc[i],       m_fc[i]);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    if (Reset) model_reset();
    else model_seq();
    @(negedge Clk);
  endtask

  task automatic idle(input int n);
    set_in(NOP, 0, 0, 0, 0);
    for (int k = 0; k < n; k++) begin
      settle(); tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] base;
    logic [4:0]  rs, rt;
    logic [31:0] ins;

    Reset = 1'b1;
    set_in(NOP, 0, 0, 0, 0);
    model_reset();
    @(negedge Clk);
    settle();
    check("reset.a.ctrl_state", 32'(o_st[0]), 32'd0);
    check("reset.b.stall_cycles", o_sc[1], 32'd0);
    check("reset.c.pc_write", 32'(o_pw[2]), 32'd1);
    tick();
    Reset = 1'b0;
    idle(2);

    // Load-use: lw $t0 in EX, add $t1,$t0,$t2 in ID
    set_in(ADD_T1_T0_T2, 1, 5'd8, 0, 0);
    settle();
    check("lu.a.pc_write", 32'(o_pw[0]), 32'd0);
    check("lu.a.if_id_write", 32'(o_ifw[0]), 32'd0);
    check("lu.a.id_ex_flush", 32'(o_idf[0]), 32'd1);
    tick();
    set_in(NOP, 0, 0, 0, 0);
    settle();
    check("lu_after.a.pc_write", 32'(o_pw[0]), 32'd1);
    check("lu_after.a.id_ex_flush", 32'(o_idf[0]), 32'd0);
    check("lu_after.a.stall_cycles", o_sc[0], 32'd1);
    tick();
    idle(4);

    // False hazards: load to $zero; load target only in addi's rt field
    set_in(ADD_T1_Z_Z, 1, 5'd0, 0, 0);
    settle();
    check("nohaz_zero.a.pc_write", 32'(o_pw[0]), 32'd1);
    tick();
    set_in(ADDI_T1_T3_4, 1, 5'd9, 0, 0);
    settle();
    check("nohaz_addi.b.pc_write", 32'(o_pw[1]), 32'd1);
    tick();
    set_in(ADDI_T1_T3_4, 1, 5'd8, 0, 0);
    settle();
    check("nohaz_addi8.a.pc_write", 32'(o_pw[0]), 32'd1);
    tick();
    idle(2);

    // Jump: jal decoded in ID
    base = m_fc[1];
    set_in(JAL_INSTR, 0, 0, 0, 0);
    settle();
    check("jal.b.if_id_flush", 32'(o_iff[1]), 32'd1);
    check("jal.b.id_ex_flush", 32'(o_idf[1]), 32'd0);
    check("jal.a.if_id_flush", 32'(o_iff[0]), 32'd1);
    tick();
    set_in(NOP, 0, 0, 0, 0);
    settle();
    check("jal+1.a.if_id_flush", 32'(o_iff[0]), 32'd0);
    check("jal+1.b.ctrl_state", 32'(o_st[1]), 32'd2);
    tick();
    settle();
    check("jal+2.b.if_id_flush", 32'(o_iff[1]), 32'd1);
    tick();
    settle();
    check("jal+3.b.ctrl_state", 32'(o_st[1]), 32'd0);
    check("jal+3.b.flush_cycles", o_fc[1], base + 32'd3);
    tick();
    idle(3);

    // Branch and load-use in the same cycle
    base = m_sc[0];
    set_in(ADD_T1_T0_T2, 1, 5'd8, 1, 0);
    settle();
    check("simul.a.if_id_flush", 32'(o_iff[0]), 32'd1);
    check("simul.a.id_ex_flush", 32'(o_idf[0]), 32'd1);
    check("simul.a.pc_write", 32'(o_pw[0]), 32'd1);
    tick();
    set_in(NOP, 0, 0, 0, 0);
    settle();
    check("simul.a.stall_cycles", o_sc[0], base);
    tick();
    idle(6);

    // Branch in the second cycle of a 3-cycle stall
    set_in(ADD_T1_T0_T2, 1, 5'd8, 0, 0);
    settle();
    check("midstall.b.pc_write0", 32'(o_pw[1]), 32'd0);
    tick();
    set_in(NOP, 0, 0, 1, 0);
    settle();
    check("midstall.b.state_stall", 32'(o_st[1]), 32'd1);
    check("midstall.b.pc_write", 32'(o_pw[1]), 32'd1);
    check("midstall.b.if_id_flush", 32'(o_iff[1]), 32'd1);
    tick();
    set_in(NOP, 0, 0, 0, 0);
    settle();
    check("midstall.b.state_run", 32'(o_st[1]), 32'd0);
    tick();
    idle(6);

    // Reset after one FLUSH cycle of a 4-cycle branch flush
    set_in(NOP, 0, 0, 1, 0);
    settle(); tick();
    set_in(NOP, 0, 0, 0, 0);
    settle();
    check("rstflush.c.state_flush", 32'(o_st[2]), 32'd2);
    tick();
    Reset = 1'b1;
    model_reset();
    settle();
    check("rstflush.c.ctrl_state", 32'(o_st[2]), 32'd0);
    check("rstflush.c.if_id_flush", 32'(o_iff[2]), 32'd0);
    check("rstflush.c.flush_cycles", o_fc[2], 32'd0);
    check("rstflush.c.stall_cycles", o_sc[2], 32'd0);
    tick();
    Reset = 1'b0;
    idle(2);

    // Saturation: preset stall counter near the top, then a 3-cycle stall
    force dut_b.u_stall_cnt.count = 32'hFFFF_FFFE;
    #1;
    release dut_b.u_stall_cnt.count;
    m_sc[1] = 32'hFFFF_FFFE;
    set_in(ADD_T1_T0_T2, 1, 5'd8, 0, 0);
    settle(); tick();
    set_in(NOP, 0, 0, 0, 0);
    settle(); tick();
    settle(); tick();
    settle();
    check("sat.b.stall_cycles", o_sc[1], 32'hFFFF_FFFF);
    tick();
    set_in(NOP, 0, 0, 0, 1);
    settle(); tick();
    set_in(NOP, 0, 0, 0, 0);
    settle();
    check("clr.b.stall_cycles", o_sc[1], 32'd0);
    check("clr.c.flush_cycles", o_fc[2], 32'd0);
    tick();

    // Randomised traffic
    for (int n = 0; n < 600; n++) begin
      rs = 5'($urandom_range(0, 7));
      rt = 5'($urandom_range(0, 7));
      case ($urandom_range(0, 10))
        0:  ins = {6'h00, rs, rt, 5'd9, 5'd0, 6'h20};
        1:  ins = {6'h00, rs, 15'd0, 6'h08};
        2:  ins = {6'h02, 26'($urandom)};
        3:  ins = {6'h03, 26'($urandom)};
        4:  ins = {6'h04, rs, rt, 16'($urandom)};
        5:  ins = {6'h05, rs, rt, 16'($urandom)};
        6:  ins = {6'h2B, rs, rt, 16'($urandom)};
        7:  ins = {6'h29, rs, rt, 16'($urandom)};
        8:  ins = {6'h28, rs, rt, 16'($urandom)};
        9:  ins = {6'h23, rs, rt, 16'($urandom)};
        default: ins = {6'h08, rs, rt, 16'($urandom)};
      endcase
      set_in(ins, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
             ($urandom_range(0, 7) == 0), ($urandom_range(0, 31) == 0));
      if ($urandom_range(0, 149) == 0) begin
        Reset = 1'b1;
        model_reset();
      end
      settle();
      tick();
      Reset = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
